// File: rtl/sram_bank_ctrl_if.sv
// sram_bank_ctrl_if: bus, retention and sram-side signals of one bank controller
interface sram_bank_ctrl_if #(
    parameter int NumWords  = 8192,
    parameter int AddrWidth = $clog2(NumWords)
);
    logic                 bus_req;
    logic                 bus_gnt;
    logic                 bus_we;
    logic [AddrWidth-1:0] bus_addr;
    logic [31:0]          bus_wdata;
    logic [3:0]           bus_be;
    logic                 bus_rvalid;
    logic [31:0]          bus_rdata;
    logic                 ret_req;
    logic                 ret_ack;
    logic                 sram_req;
    logic                 sram_we;
    logic [AddrWidth-1:0] sram_addr;
    logic [31:0]          sram_wdata;
    logic [3:0]           sram_be;
    logic                 sram_set_retentive_n;
    logic [31:0]          sram_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be, ret_req, sram_rdata,
        input  bus_gnt, bus_rvalid, bus_rdata, ret_ack,
        input  sram_req, sram_we, sram_addr, sram_wdata, sram_be, sram_set_retentive_n
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be, ret_req, sram_rdata,
        output bus_gnt, bus_rvalid, bus_rdata, ret_ack,
        output sram_req, sram_we, sram_addr, sram_wdata, sram_be, sram_set_retentive_n
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: bus front-end for one sram bank with retention sequencing and wake-up settle time
module sram_bank_ctrl #(
    parameter int NumWords      = 8192,
    parameter int AddrWidth     = $clog2(NumWords),
    parameter int WakeupCycles  = 4,
    parameter int IdleRetCycles = 0
) (
    input logic             clk,
    input logic             rst,
    sram_bank_ctrl_if.slave bus
);
    localparam int MaxCnt   = (WakeupCycles > IdleRetCycles) ? WakeupCycles : IdleRetCycles;
    localparam int CntWidth = $clog2(MaxCnt + 1);
    localparam logic [CntWidth-1:0] WakeInit = CntWidth'(WakeupCycles);
    localparam logic [CntWidth-1:0] IdleMax  = CntWidth'(IdleRetCycles);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    typedef enum logic [1:0] {WAKEUP, ACTIVE, RETENTIVE} state_t;

    state_t               state, state_next;
    logic [CntWidth-1:0]  wake_cnt, wake_cnt_next, idle_cnt, idle_cnt_next;
    logic                 auto_ret, auto_ret_next;
    logic                 gnt, rvalid, read_q, ret_n;
    logic [AddrWidth-1:0] addr;

    always_comb begin
        state_next    = state;
        wake_cnt_next = wake_cnt;
        idle_cnt_next = '0;
        auto_ret_next = auto_ret;
        gnt           = 1'b0;
        case (state)
            WAKEUP: begin
                if (wake_cnt <= CntOne) state_next = ACTIVE;
                else wake_cnt_next = wake_cnt - CntOne;
            end
            ACTIVE: begin
                gnt           = bus.bus_req & ~bus.ret_req;
                idle_cnt_next = bus.bus_req ? '0 : (idle_cnt == IdleMax ? idle_cnt : idle_cnt + CntOne);
                if (bus.ret_req) begin
                    state_next    = RETENTIVE;
                    auto_ret_next = 1'b0;
                    idle_cnt_next = '0;
                end else if (IdleRetCycles != 0 && idle_cnt_next == IdleMax) begin
                    state_next    = RETENTIVE;
                    auto_ret_next = 1'b1;
                    idle_cnt_next = '0;
                end
            end
            RETENTIVE: begin
                // auto-entered retention is only left when there is traffic to serve
                if (!bus.ret_req && (!auto_ret || bus.bus_req)) begin
                    state_next    = WAKEUP;
                    wake_cnt_next = WakeInit;
                end
            end
            default: state_next = WAKEUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAKEUP;
            wake_cnt <= WakeInit;
            idle_cnt <= '0;
            auto_ret <= 1'b0;
            rvalid   <= 1'b0;
            read_q   <= 1'b0;
            ret_n    <= 1'b1;
        end else begin
            state    <= state_next;
            wake_cnt <= wake_cnt_next;
            idle_cnt <= idle_cnt_next;
            auto_ret <= auto_ret_next;
            rvalid   <= gnt;
            read_q   <= gnt & ~bus.bus_we;
            ret_n    <= state_next != RETENTIVE;
        end
    end

    assign addr                     = bus.bus_addr;
    assign bus.bus_gnt              = gnt;
    assign bus.sram_req             = gnt;
    assign bus.sram_we              = bus.bus_we;
    assign bus.sram_addr            = addr;
    assign bus.sram_wdata           = bus.bus_wdata;
    assign bus.sram_be              = bus.bus_be;
    assign bus.bus_rvalid           = rvalid;
    assign bus.bus_rdata            = (rvalid & read_q) ? bus.sram_rdata : '0;
    assign bus.ret_ack              = ~ret_n;
    assign bus.sram_set_retentive_n = ret_n;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: directed scenarios plus randomized traffic checked against a timeline model
module tb_sram_bank_ctrl;
    localparam int NumWords = 8192;
    localparam int AW       = $clog2(NumWords);
    localparam int Wake     = 4;
    localparam int Idle     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sram_bank_ctrl_if #(.NumWords(NumWords)) bus ();
    sram_bank_ctrl #(.NumWords(NumWords), .WakeupCycles(Wake), .IdleRetCycles(Idle)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // stub memory standing in for the sram bank: one-cycle read latency
    logic [31:0] mem [NumWords];
    always @(posedge clk) begin
        if (bus.sram_req && bus.sram_we)
            for (int b = 0; b < 4; b++)
                if (bus.sram_be[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        if (bus.sram_req && !bus.sram_we) bus.sram_rdata <= mem[bus.sram_addr];
    end

    // reference model: grants allowed from cycle ready_at onward unless retained
    logic [31:0] ref_mem [NumWords];
    int          cyc      = 0;
    int          ready_at = 1 << 30;
    int          idle     = 0;
    bit          in_ret   = 1'b0;
    bit          auto_ret = 1'b0;
    bit          prev_gnt = 1'b0;
    bit          exp_gnt  = 1'b0;
    logic [31:0] prev_rdata = '0;

    function automatic bit model_gnt();
        return !in_ret && cyc >= ready_at && bus.bus_req && !bus.ret_req;
    endfunction

    task automatic drive(input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input bit ret);
        bus.bus_req   = req;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        bus.bus_be    = be;
        bus.ret_req   = ret;
    endtask

    task automatic settle();
        @(negedge clk);
        exp_gnt = model_gnt();
    endtask

    task automatic adv();
        bit g;
        bit was_active;
        @(posedge clk);
        g = model_gnt();
        was_active = !in_ret && cyc >= ready_at;
        prev_gnt   = g;
        prev_rdata = (g && !bus.bus_we) ? ref_mem[bus.bus_addr] : '0;
        if (g && bus.bus_we)
            for (int b = 0; b < 4; b++)
                if (bus.bus_be[b]) ref_mem[bus.bus_addr][8*b +: 8] = bus.bus_wdata[8*b +: 8];
        cyc++;
        if (rst) begin
            in_ret = 0; auto_ret = 0; idle = 0; ready_at = cyc + Wake; prev_gnt = 0; prev_rdata = '0;
        end else if (in_ret) begin
            if (!bus.ret_req && (!auto_ret || bus.bus_req)) begin
                in_ret = 0; ready_at = cyc + Wake;
            end
        end else if (was_active) begin
            if (bus.ret_req) begin
                in_ret = 1; auto_ret = 0; idle = 0;
            end else begin
                idle = bus.bus_req ? 0 : (idle < Idle ? idle + 1 : idle);
                if (Idle != 0 && idle == Idle) begin
                    in_ret = 1; auto_ret = 1; idle = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 'h10, '0, 4'hf, 0);
        adv();
        adv();
        rst = 1'b0;
        settle();
        checks++; if (bus.bus_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", bus.bus_gnt); end
        checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got %b exp 0", bus.sram_req); end
        checks++; if (bus.bus_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus.bus_rvalid); end
        checks++; if (bus.ret_ack !== 1'b0) begin errors++; $display("FAIL reset_ret_ack got %b exp 0", bus.ret_ack); end
        checks++; if (bus.sram_set_retentive_n !== 1'b1) begin errors++; $display("FAIL reset_ret_n got %b exp 1", bus.sram_set_retentive_n); end
        adv();
    endtask

    task automatic test_first_read();
        rst = 1'b1;
        drive(1, 0, 'h10, '0, 4'hf, 0);
        adv();
        rst = 1'b0;
        for (int i = 0; i <= Wake; i++) begin
            settle();
            checks++; if (bus.bus_gnt !== (i == Wake)) begin errors++; $display("FAIL wake_gnt cycle %0d got %b exp %b", i, bus.bus_gnt, i == Wake); end
            adv();
        end
        drive(0, 0, '0, '0, 4'h0, 0);
        settle();
        checks++; if (bus.bus_rvalid !== 1'b1) begin errors++; $display("FAIL first_rvalid got %b exp 1", bus.bus_rvalid); end
        checks++; if (bus.bus_rdata !== 32'hA5A5_0010) begin errors++; $display("FAIL first_rdata got %h exp a5a50010", bus.bus_rdata); end
        adv();
    endtask

    task automatic test_write_read();
        drive(1, 1, 'h20, 32'hDEAD_BEEF, 4'b0101, 0);
        settle();
        checks++; if (bus.bus_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", bus.bus_gnt); end
        adv();
        drive(1, 0, 'h20, '0, 4'hf, 0);
        settle();
        checks++; if (bus.bus_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", bus.bus_gnt); end
        checks++; if (bus.bus_rvalid !== 1'b1 || bus.bus_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp got %b/%h exp 1/00000000", bus.bus_rvalid, bus.bus_rdata); end
        adv();
        drive(0, 0, '0, '0, 4'h0, 0);
        settle();
        checks++; if (bus.bus_rvalid !== 1'b1 || bus.bus_rdata !== 32'h00AD_00EF) begin errors++; $display("FAIL rd_resp got %b/%h exp 1/00ad00ef", bus.bus_rvalid, bus.bus_rdata); end
        adv();
    endtask

    task automatic test_ret_req();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, AW'($urandom_range(0, 63)), '0, 4'hf, 0);
            settle();
            checks++; if (bus.bus_gnt !== 1'b1) begin errors++; $display("FAIL stream_gnt %0d got %b exp 1", i, bus.bus_gnt); end
            adv();
        end
        drive(1, 0, 'h5, '0, 4'hf, 1);
        settle();
        checks++; if (bus.bus_gnt !== 1'b0 || bus.bus_rvalid !== 1'b1) begin errors++; $display("FAIL ret_edge gnt/rvalid got %b/%b exp 0/1", bus.bus_gnt, bus.bus_rvalid); end
        adv();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (bus.sram_set_retentive_n !== 1'b0 || bus.ret_ack !== 1'b1 || bus.sram_req !== 1'b0) begin
                errors++; $display("FAIL ret_hold %0d ret_n/ack/sram_req got %b/%b/%b exp 0/1/0", i, bus.sram_set_retentive_n, bus.ret_ack, bus.sram_req); end
            adv();
        end
        drive(1, 0, 'h5, '0, 4'hf, 0);
        settle();
        adv();
        for (int j = 0; j <= Wake; j++) begin
            settle();
            if (j == 0) begin
                checks++; if (bus.sram_set_retentive_n !== 1'b1 || bus.ret_ack !== 1'b0) begin errors++; $display("FAIL ret_exit ret_n/ack got %b/%b exp 1/0", bus.sram_set_retentive_n, bus.ret_ack); end
            end
            checks++; if (bus.bus_gnt !== (j == Wake)) begin errors++; $display("FAIL rewake_gnt cycle %0d got %b exp %b", j, bus.bus_gnt, j == Wake); end
            adv();
        end
        drive(0, 0, '0, '0, 4'h0, 0);
    endtask

    task automatic test_auto_ret();
        for (int i = 0; i < Idle; i++) begin
            settle();
            checks++; if (bus.ret_ack !== 1'b0) begin errors++; $display("FAIL idle_ack cycle %0d got %b exp 0", i, bus.ret_ack); end
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (bus.ret_ack !== 1'b1 || bus.sram_set_retentive_n !== 1'b0) begin errors++; $display("FAIL auto_ret %0d ack/ret_n got %b/%b exp 1/0", i, bus.ret_ack, bus.sram_set_retentive_n); end
            adv();
        end
        drive(1, 1, 'h30, 32'h1234_5678, 4'hf, 0);
        for (int j = 0; j <= Wake + 1; j++) begin
            settle();
            checks++; if (bus.bus_gnt !== (j == Wake + 1)) begin errors++; $display("FAIL auto_wake_gnt cycle %0d got %b exp %b", j, bus.bus_gnt, j == Wake + 1); end
            adv();
        end
        drive(0, 0, '0, '0, 4'h0, 0);
    endtask

    task automatic test_reset_in_ret();
        drive(0, 0, '0, '0, 4'h0, 1);
        settle();
        adv();
        settle();
        checks++; if (bus.ret_ack !== 1'b1) begin errors++; $display("FAIL pre_rst_ack got %b exp 1", bus.ret_ack); end
        rst = 1'b1;
        adv();
        rst = 1'b0;
        drive(1, 0, 'h30, '0, 4'hf, 0);
        for (int i = 0; i <= Wake; i++) begin
            settle();
            if (i == 0) begin
                checks++; if (bus.sram_set_retentive_n !== 1'b1 || bus.ret_ack !== 1'b0 || bus.bus_rvalid !== 1'b0) begin
                    errors++; $display("FAIL rst_in_ret ret_n/ack/rvalid got %b/%b/%b exp 1/0/0", bus.sram_set_retentive_n, bus.ret_ack, bus.bus_rvalid); end
            end
            checks++; if (bus.bus_gnt !== (i == Wake)) begin errors++; $display("FAIL rst_wake_gnt cycle %0d got %b exp %b", i, bus.bus_gnt, i == Wake); end
            adv();
        end
        drive(0, 0, '0, '0, 4'h0, 0);
    endtask

    task automatic test_random();
        bit          p_req = 0, p_we = 0;
        logic [AW-1:0] p_addr = '0;
        logic [31:0] p_wdata = '0;
        logic [3:0]  p_be = '0;
        for (int k = 0; k < 600; k++) begin
            if (!p_req) begin
                p_req   = ((k / 60) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
                p_we    = $urandom_range(0, 1) == 1;
                p_addr  = AW'($urandom_range(0, 63));
                p_wdata = $urandom;
                p_be    = 4'($urandom_range(0, 15));
            end
            rst = $urandom_range(0, 199) == 0;
            drive(p_req, p_we, p_addr, p_wdata, p_be, $urandom_range(0, 15) == 0);
            settle();
            checks++; if (bus.bus_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, bus.bus_gnt, exp_gnt); end
            checks++; if (bus.sram_req !== exp_gnt) begin errors++; $display("FAIL rnd_sram_req cyc %0d got %b exp %b", cyc, bus.sram_req, exp_gnt); end
            checks++; if (bus.bus_rvalid !== prev_gnt) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", cyc, bus.bus_rvalid, prev_gnt); end
            checks++; if (bus.bus_rdata !== prev_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, bus.bus_rdata, prev_rdata); end
            checks++; if (bus.ret_ack !== in_ret) begin errors++; $display("FAIL rnd_ret_ack cyc %0d got %b exp %b", cyc, bus.ret_ack, in_ret); end
            checks++; if (bus.sram_set_retentive_n !== !in_ret) begin errors++; $display("FAIL rnd_ret_n cyc %0d got %b exp %b", cyc, bus.sram_set_retentive_n, !in_ret); end
            if (exp_gnt || rst) p_req = 0;
            adv();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NumWords; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[16]        = 32'hA5A5_0010;
        ref_mem[16]    = 32'hA5A5_0010;
        bus.sram_rdata = '0;
        drive(0, 0, '0, '0, 4'h0, 0);
        test_reset();
        test_first_read();
        test_write_read();
        test_ret_req();
        test_auto_ret();
        test_reset_in_ret();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
